// File: rtl/jtcontra_gfxrom_slot_if.sv
// Bus bundle between the two jtcontra_gfx fetchers, the ROM slot and the SDRAM read port.
// Handshakes: gfxN_ok is a level (data valid for the current gfxN_addr while cs is high);
// sdram_req is held until a one-cycle sdram_ack, and data returns on a later one-cycle sdram_rdy.
interface jtcontra_gfxrom_slot_if;
  logic [17:0] gfx1_addr;
  logic        gfx1_cs;
  logic [15:0] gfx1_data;
  logic        gfx1_ok;
  logic [17:0] gfx2_addr;
  logic        gfx2_cs;
  logic [15:0] gfx2_data;
  logic        gfx2_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack;
  logic        sdram_rdy;
  logic [15:0] sdram_din;

  modport slave (
    input  gfx1_addr, gfx1_cs, gfx2_addr, gfx2_cs, sdram_ack, sdram_rdy, sdram_din,
    output gfx1_data, gfx1_ok, gfx2_data, gfx2_ok, sdram_addr, sdram_req
  );

  modport master (
    output gfx1_addr, gfx1_cs, gfx2_addr, gfx2_cs, sdram_ack, sdram_rdy, sdram_din,
    input  gfx1_data, gfx1_ok, gfx2_data, gfx2_ok, sdram_addr, sdram_req
  );
endinterface

// File: rtl/jtcontra_gfxrom_slot.sv
// Two-client graphics ROM slot: one-word cache per client, round-robin SDRAM fetches.
// Optional next-word prefetch per client is enabled by defining JTCONTRA_GFXROM_PREFETCH_EN.
module jtcontra_gfxrom_slot #(
  parameter logic [21:0] GFX1_OFFSET = 22'h0,
  parameter logic [21:0] GFX2_OFFSET = 22'h40000
) (
  input  logic                         clk,
  input  logic                         rst,
  jtcontra_gfxrom_slot_if.slave        bus,
  output logic [1:0]                   dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        rr_q, rr_d;
  logic [21:0] req_addr_q, req_addr_d;
  logic [17:0] req_tag_q, req_tag_d;
  logic [17:0] tag_q [2];
  logic [17:0] tag_d [2];
  logic [15:0] word_q [2];
  logic [15:0] word_d [2];
  logic [1:0]  valid_q, valid_d;

  logic [17:0] addr [2];
  logic [1:0]  cs, hit, miss, dmiss;
  logic        grant;

`ifdef JTCONTRA_GFXROM_PREFETCH_EN
  logic [17:0] ptag_q [2];
  logic [17:0] ptag_d [2];
  logic [15:0] pword_q [2];
  logic [15:0] pword_d [2];
  logic [1:0]  pvalid_q, pvalid_d;
  logic [1:0]  pf_pend_q, pf_pend_d;
  logic        pf_q, pf_d;
  logic [1:0]  promo;
  logic        pf_sel;
  logic [17:0] pf_tag;
`endif

  // Cache lookup and arbitration
  always_comb begin
    addr[0] = bus.gfx1_addr;
    addr[1] = bus.gfx2_addr;
    cs      = {bus.gfx2_cs, bus.gfx1_cs};
    for (int i = 0; i < 2; i++) begin
      hit[i] = cs[i] & valid_q[i] & (addr[i] == tag_q[i]);
    end
    miss = cs & ~hit;
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
    for (int i = 0; i < 2; i++) begin
      promo[i] = miss[i] & pvalid_q[i] & (addr[i] == ptag_q[i]);
    end
    // A miss served from the prefetch entry never reaches SDRAM
    dmiss  = miss & ~promo;
    pf_sel = ~pf_pend_q[0];
    pf_tag = tag_q[pf_sel] + 18'd1;
`else
    dmiss = miss;
`endif
    grant = (dmiss == 2'b11) ? rr_q : dmiss[1];
  end

  always_comb begin
    bus.gfx1_ok    = hit[0];
    bus.gfx2_ok    = hit[1];
    bus.gfx1_data  = word_q[0];
    bus.gfx2_data  = word_q[1];
    bus.sdram_req  = (state_q == ST_REQ);
    bus.sdram_addr = req_addr_q;
    dbg_state      = state_q;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    req_addr_d = req_addr_q;
    req_tag_d  = req_tag_q;
    tag_d      = tag_q;
    word_d     = word_q;
    valid_d    = valid_q;
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
    ptag_d    = ptag_q;
    pword_d   = pword_q;
    pvalid_d  = pvalid_q;
    pf_pend_d = pf_pend_q;
    pf_d      = pf_q;
    for (int i = 0; i < 2; i++) begin
      if (promo[i]) begin
        tag_d[i]    = ptag_q[i];
        word_d[i]   = pword_q[i];
        valid_d[i]  = 1'b1;
        pvalid_d[i] = 1'b0;
      end
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (dmiss != 2'b00) begin
          gnt_d      = grant;
          rr_d       = ~grant;
          req_tag_d  = addr[grant];
          req_addr_d = (grant ? GFX2_OFFSET : GFX1_OFFSET) + {4'b0, addr[grant]};
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
          pf_d       = 1'b0;
`endif
          state_d    = ST_REQ;
        end
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
        else if (miss == 2'b00 && pf_pend_q != 2'b00) begin
          gnt_d             = pf_sel;
          pf_pend_d[pf_sel] = 1'b0;
          req_tag_d         = pf_tag;
          req_addr_d        = (pf_sel ? GFX2_OFFSET : GFX1_OFFSET) + {4'b0, pf_tag};
          pf_d              = 1'b1;
          state_d           = ST_REQ;
        end
`endif
      end
      // rdy arriving together with ack is not data for this request
      ST_REQ: begin
        if (bus.sdram_ack) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.sdram_rdy) begin
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
          if (pf_q) begin
            ptag_d[gnt_q]   = req_tag_q;
            pword_d[gnt_q]  = bus.sdram_din;
            pvalid_d[gnt_q] = 1'b1;
          end else begin
            tag_d[gnt_q]     = req_tag_q;
            word_d[gnt_q]    = bus.sdram_din;
            valid_d[gnt_q]   = 1'b1;
            pf_pend_d[gnt_q] = 1'b1;
          end
`else
          tag_d[gnt_q]   = req_tag_q;
          word_d[gnt_q]  = bus.sdram_din;
          valid_d[gnt_q] = 1'b1;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      rr_q       <= 1'b0;
      req_addr_q <= '0;
      req_tag_q  <= '0;
      tag_q      <= '{default: '0};
      word_q     <= '{default: '0};
      valid_q    <= '0;
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
      ptag_q    <= '{default: '0};
      pword_q   <= '{default: '0};
      pvalid_q  <= '0;
      pf_pend_q <= '0;
      pf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      req_addr_q <= req_addr_d;
      req_tag_q  <= req_tag_d;
      tag_q      <= tag_d;
      word_q     <= word_d;
      valid_q    <= valid_d;
`ifdef JTCONTRA_GFXROM_PREFETCH_EN
      ptag_q    <= ptag_d;
      pword_q   <= pword_d;
      pvalid_q  <= pvalid_d;
      pf_pend_q <= pf_pend_d;
      pf_q      <= pf_d;
`endif
    end
  end

endmodule

// File: tb/tb_jtcontra_gfxrom_slot.sv
// Bench for jtcontra_gfxrom_slot: directed protocol steps, then randomized traffic
// checked against a per-client cache model and an address-derived SDRAM content function.
module tb_jtcontra_gfxrom_slot;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  int         vectors = 0;
  int         errors  = 0;

  jtcontra_gfxrom_slot_if bus ();

  jtcontra_gfxrom_slot dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  // SDRAM contents as a fixed function of the word address
  function automatic logic [15:0] mem(input logic [21:0] a);
    logic [31:0] p;
    p = {10'b0, a} * 32'd40503;
    return p[15:0] ^ {10'b0, a[21:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.gfx1_cs = 1'b0; bus.gfx1_addr = '0;
    bus.gfx2_cs = 1'b0; bus.gfx2_addr = '0;
    bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_din = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // Wait for a request, ack after ack_dly cycles, return data rdy_dly (>=1) cycles after the ack
  task automatic serve(input int ack_dly, input int rdy_dly, input logic [15:0] din,
                       output logic [21:0] got);
    int n;
    n = 0;
    while (!bus.sdram_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(n < 20), 32'd1);
    got = bus.sdram_addr;
    repeat (ack_dly) tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    repeat (rdy_dly - 1) tick();
    bus.sdram_rdy = 1'b1;
    bus.sdram_din = din;
    tick();
    bus.sdram_rdy = 1'b0;
  endtask

  // Reference model state for the randomized phase
  logic        mvalid [2];
  logic [17:0] mtag [2];
  logic [15:0] mword [2];
  logic [17:0] a_in [2];
  logic        c_in [2];
  int          age [2];
  int          phase, cnt;
  logic [21:0] cur;
  logic        fill;
  logic        exp_ok;
  logic [21:0] g;

  initial begin
    // Reset values, with a request already presented
    rst = 1'b1;
    bus.gfx1_cs = 1'b1; bus.gfx1_addr = 18'h00010;
    bus.gfx2_cs = 1'b0; bus.gfx2_addr = '0;
    bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0; bus.sdram_din = '0;
    repeat (3) tick();
    chk("rst_req",   32'(bus.sdram_req), 32'd0);
    chk("rst_addr",  32'(bus.sdram_addr), 32'd0);
    chk("rst_ok1",   32'(bus.gfx1_ok), 32'd0);
    chk("rst_ok2",   32'(bus.gfx2_ok), 32'd0);
    chk("rst_data1", 32'(bus.gfx1_data), 32'd0);
    chk("rst_data2", 32'(bus.gfx2_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // First miss: ack one cycle after req, rdy three cycles after the ack
    rst = 1'b0;
    tick();
    chk("t1_req",  32'(bus.sdram_req), 32'd1);
    chk("t1_addr", 32'(bus.sdram_addr), 32'h00010);
    chk("t1_ok_early", 32'(bus.gfx1_ok), 32'd0);
    tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    #1 chk("t1_req_drop", 32'(bus.sdram_req), 32'd0);
    tick();
    tick();
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hA55A;
    #1 chk("t1_ok_pre_rdy", 32'(bus.gfx1_ok), 32'd0);
    tick();
    bus.sdram_rdy = 1'b0;
    #1;
    chk("t1_ok",   32'(bus.gfx1_ok), 32'd1);
    chk("t1_data", 32'(bus.gfx1_data), 32'hA55A);
    chk("t1_ok2",  32'(bus.gfx2_ok), 32'd0);

    // Held address hits; a new address misses in the same cycle
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_req", 32'(bus.sdram_req), 32'd0);
      chk("t2_hold_ok",  32'(bus.gfx1_ok), 32'd1);
    end
    bus.gfx1_addr = 18'h00011;
    #1 chk("t2_miss_ok", 32'(bus.gfx1_ok), 32'd0);
    serve(0, 1, 16'h1111, g);
    chk("t2_addr", 32'(g), 32'h00011);
    #1;
    chk("t2_ok",   32'(bus.gfx1_ok), 32'd1);
    chk("t2_data", 32'(bus.gfx1_data), 32'h1111);

    // Simultaneous misses and round-robin order
    do_reset();
    bus.gfx1_cs = 1'b1; bus.gfx1_addr = 18'h1;
    bus.gfx2_cs = 1'b1; bus.gfx2_addr = 18'h2;
    serve(0, 1, 16'hD001, g);
    chk("t3_first",  32'(g), 32'h00001);
    serve(1, 2, 16'hD002, g);
    chk("t3_second", 32'(g), 32'h40002);
    #1;
    chk("t3_ok1", 32'(bus.gfx1_ok), 32'd1);
    chk("t3_ok2", 32'(bus.gfx2_ok), 32'd1);
    chk("t3_d1",  32'(bus.gfx1_data), 32'hD001);
    chk("t3_d2",  32'(bus.gfx2_data), 32'hD002);
    bus.gfx2_cs = 1'b0;
    bus.gfx1_addr = 18'h3;
    serve(0, 1, 16'hD003, g);
    chk("t3_single", 32'(g), 32'h00003);
    bus.gfx1_addr = 18'h4;
    bus.gfx2_cs = 1'b1; bus.gfx2_addr = 18'h5;
    serve(0, 1, 16'hD005, g);
    chk("t3_rr_first",  32'(g), 32'h40005);
    serve(0, 1, 16'hD004, g);
    chk("t3_rr_second", 32'(g), 32'h00004);
    #1;
    chk("t3_ok1b", 32'(bus.gfx1_ok), 32'd1);
    chk("t3_d2b",  32'(bus.gfx2_data), 32'hD005);

    // Address change while the fetch is in WAIT
    bus.gfx2_cs = 1'b0;
    bus.gfx1_addr = 18'h5;
    tick();
    chk("t4_addr5", 32'(bus.sdram_addr), 32'h00005);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    bus.gfx1_addr = 18'h6;
    tick();
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'h5555;
    tick();
    bus.sdram_rdy = 1'b0;
    #1;
    chk("t4_ok_stale",  32'(bus.gfx1_ok), 32'd0);
    chk("t4_data_fill", 32'(bus.gfx1_data), 32'h5555);
    bus.gfx1_addr = 18'h5;
    #1 chk("t4_tag_old", 32'(bus.gfx1_ok), 32'd1);
    bus.gfx1_addr = 18'h6;
    tick();
    chk("t4_new_req",  32'(bus.sdram_req), 32'd1);
    chk("t4_new_addr", 32'(bus.sdram_addr), 32'h00006);
    serve(0, 1, 16'h6666, g);
    #1 chk("t4_ok6", 32'(bus.gfx1_ok), 32'd1);

    // Reset while in WAIT; the late rdy must not fill
    bus.gfx2_cs = 1'b1; bus.gfx2_addr = 18'h5;
    #1 chk("t5_ok2_pre", 32'(bus.gfx2_ok), 32'd1);
    bus.gfx1_addr = 18'h7;
    tick();
    chk("t5_addr7", 32'(bus.sdram_addr), 32'h00007);
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    bus.gfx2_cs = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.gfx1_cs = 1'b0;
    #1 chk("t5_req_rst", 32'(bus.sdram_req), 32'd0);
    tick();
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hBEEF;
    tick();
    bus.sdram_rdy = 1'b0;
    #1;
    chk("t5_req_late",  32'(bus.sdram_req), 32'd0);
    chk("t5_data_late", 32'(bus.gfx1_data), 32'd0);
    bus.gfx1_cs = 1'b1; bus.gfx2_cs = 1'b1;
    #1;
    chk("t5_ok1_inval", 32'(bus.gfx1_ok), 32'd0);
    chk("t5_ok2_inval", 32'(bus.gfx2_ok), 32'd0);
    serve(0, 1, 16'h7777, g);
    chk("t5_refetch1", 32'(g), 32'h00007);
    serve(0, 1, 16'h5050, g);
    chk("t5_refetch2", 32'(g), 32'h40005);

    // Spurious rdy in REQ, rdy coincident with ack, spurious rdy in IDLE
    bus.gfx2_cs = 1'b0;
    bus.gfx1_addr = 18'h8;
    tick();
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hDEAD;
    tick();
    bus.sdram_rdy = 1'b0;
    chk("t6_req_hold", 32'(bus.sdram_req), 32'd1);
    bus.sdram_ack = 1'b1; bus.sdram_rdy = 1'b1;
    tick();
    bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0;
    #1;
    chk("t6_req_acked", 32'(bus.sdram_req), 32'd0);
    chk("t6_no_fill",   32'(bus.gfx1_data), 32'h7777);
    tick();
    chk("t6_still_wait", 32'(bus.gfx1_ok), 32'd0);
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'h8888;
    tick();
    bus.sdram_rdy = 1'b0;
    #1 chk("t6_ok", 32'(bus.gfx1_ok), 32'd1);
    bus.sdram_rdy = 1'b1; bus.sdram_din = 16'hFFFF;
    tick();
    bus.sdram_rdy = 1'b0;
    #1;
    chk("t6_idle_rdy_data", 32'(bus.gfx1_data), 32'h8888);
    chk("t6_idle_rdy_req",  32'(bus.sdram_req), 32'd0);

    // Randomized traffic against the cache model
    do_reset();
    for (int c = 0; c < 2; c++) begin
      mvalid[c] = 1'b0; mtag[c] = '0; mword[c] = '0;
      a_in[c] = '0; c_in[c] = 1'b1; age[c] = 0;
    end
    phase = 0; cnt = 0; cur = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          a_in[c] = ($urandom_range(0, 7) == 0) ? 18'($urandom) : 18'($urandom_range(0, 7));
          age[c] = 0;
        end
        if ($urandom_range(0, 19) == 0) c_in[c] = ~c_in[c];
      end
      bus.gfx1_addr = a_in[0]; bus.gfx1_cs = c_in[0];
      bus.gfx2_addr = a_in[1]; bus.gfx2_cs = c_in[1];
      bus.sdram_ack = 1'b0; bus.sdram_rdy = 1'b0;
      fill = 1'b0;
      case (phase)
        1: begin
          if (cnt == 0) begin
            bus.sdram_ack = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
              bus.sdram_rdy = 1'b1; bus.sdram_din = 16'($urandom);
            end
            phase = 2;
            cnt = $urandom_range(0, 3);
          end else cnt--;
        end
        2: begin
          if (cnt == 0) begin
            bus.sdram_rdy = 1'b1; bus.sdram_din = mem(cur);
            fill = 1'b1;
            phase = 0;
          end else cnt--;
        end
        default: begin
          if ($urandom_range(0, 9) == 0) begin
            bus.sdram_rdy = 1'b1; bus.sdram_din = 16'($urandom);
          end
        end
      endcase
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        exp_ok = c_in[c] & mvalid[c] & (a_in[c] == mtag[c]);
        chk(c == 0 ? "rnd_ok1" : "rnd_ok2",
            32'(c == 0 ? bus.gfx1_ok : bus.gfx2_ok), 32'(exp_ok));
        chk(c == 0 ? "rnd_data1" : "rnd_data2",
            32'(c == 0 ? bus.gfx1_data : bus.gfx2_data), 32'(mword[c]));
        if (c_in[c] && !exp_ok) age[c]++;
        else age[c] = 0;
        if (age[c] > 40) begin
          chk("rnd_stall", 32'(age[c]), 32'd40);
          age[c] = 0;
        end
      end
      if (phase == 0 && !fill && bus.sdram_req) begin
        cur = bus.sdram_addr;
        chk("rnd_req_region", 32'(cur[21:19]), 32'd0);
        phase = 1;
        cnt = $urandom_range(0, 3);
      end
      @(posedge clk);
      if (fill) begin
        mvalid[cur[18]] = 1'b1;
        mtag[cur[18]]   = cur[17:0];
        mword[cur[18]]  = mem(cur);
      end
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
